writeback_stage: RTL and testbench

//  Parametrised writeback stage for the rv32 pipeline. Sits between MEM and the register file.

---
 rtl/wb_pkg.sv | 39 +++
 rtl/load_align_ext.sv | 33 +++
 rtl/writeback_stage.sv | 173 +++++++++++++++++
 tb/tb_writeback_stage.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types for the rv32 writeback stage.
//   wb_sel_e      - result source select (ALU, load data, PC+4, immediate)
//   load_size_e   - load width; the reserved encoding behaves as WORD
//   wb_state_e    - writeback FSM states
//   is_misaligned - flags loads whose byte offset does not match their width
package wb_pkg;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2,
    WB_IMM = 2'd3
  } wb_sel_e;

  typedef enum logic [1:0] {
    LS_BYTE = 2'd0,
    LS_HALF = 2'd1,
    LS_WORD = 2'd2,
    LS_RSVD = 2'd3
  } load_size_e;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } wb_state_e;

  // Bytes are never misaligned; halves need off[0]==0; words (and the
  // reserved size, which is treated as a word) need off==0.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic mis;
    case (size)
      2'd0:    mis = 1'b0;
      2'd1:    mis = off[0];
      default: mis = (off != 2'd0);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/load_align_ext.sv
// Combinational load lane select and sign/zero extension.
//   rdata [XLEN] raw aligned word from data memory
//   size  [2]    load_size_e (reserved encoding behaves as WORD)
//   uns   [1]    1 = zero-extend, 0 = sign-extend
//   off   [2]    load address [1:0]
//   result[XLEN] extended load value
// Kept standalone so the LSU forwarding path can reuse it.
module load_align_ext #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      size,
  input  logic            uns,
  input  logic [1:0]      off,
  output logic [XLEN-1:0] result
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = rdata[{off, 3'b000} +: 8];
    half_v = rdata[{off[1], 4'b0000} +: 16];
    case (size)
      2'd0:    result = uns ? {{(XLEN-8){1'b0}}, byte_v}
                            : {{(XLEN-8){byte_v[7]}}, byte_v};
      2'd1:    result = uns ? {{(XLEN-16){1'b0}}, half_v}
                            : {{(XLEN-16){half_v[15]}}, half_v};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage for the rv32 pipeline, between MEM and the register file.
// Selects the result source, aligns/extends loads, waits for variable-latency
// load responses with a timeout, and drops misaligned loads.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   in_valid / in_ready        op handshake from MEM
//   in_rd, in_reg_write        destination register and write request
//   in_wb_sel                  result source (wb_sel_e)
//   in_load_size, in_load_uns  load width and extension mode
//   in_byte_off                load address [1:0]
//   in_alu_value, in_pc_4_value, in_imm_value   non-load sources
//   mem_rvalid, mem_rdata      load response
//   rf_we, rf_waddr, rf_wdata  registered register-file write port
//   busy                       registered, high while waiting for load data
//   load_misaligned            registered pulse, misaligned load dropped
//   bus_timeout                registered pulse, load aborted
//   state_dbg                  current FSM state (wb_state_e encoding)
//
// Handshake: an op transfers on a rising edge where in_valid && in_ready.
// in_ready is a pure function of state (high only in IDLE), so it never
// depends on in_valid; MEM may hold in_valid and fields until accepted.
module writeback_stage
  import wb_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int REG_AW  = 5,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_reg_write,
  input  logic [1:0]        in_wb_sel,
  input  logic [1:0]        in_load_size,
  input  logic              in_load_uns,
  input  logic [1:0]        in_byte_off,
  input  logic [XLEN-1:0]   in_alu_value,
  input  logic [XLEN-1:0]   in_pc_4_value,
  input  logic [XLEN-1:0]   in_imm_value,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [XLEN-1:0]   rf_wdata,
  output logic              busy,
  output logic              load_misaligned,
  output logic              bus_timeout,
  output logic              state_dbg
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  wb_state_e         state, state_n;
  logic [TW-1:0]     timer, timer_n;

  // Hold register: load attributes captured at accept time.
  logic [REG_AW-1:0] hold_rd;
  logic              hold_reg_write;
  logic [1:0]        hold_size;
  logic              hold_uns;
  logic [1:0]        hold_off;

  logic              rf_we_n, mis_n, to_n;
  logic [REG_AW-1:0] rf_waddr_n;
  logic [XLEN-1:0]   rf_wdata_n;
  logic [XLEN-1:0]   src_value;
  logic [XLEN-1:0]   load_value;
  logic              accept;

  assign in_ready  = (state == IDLE);
  assign accept    = in_valid && in_ready;
  assign state_dbg = state;

  load_align_ext #(.XLEN(XLEN)) u_align (
    .rdata  (mem_rdata),
    .size   (hold_size),
    .uns    (hold_uns),
    .off    (hold_off),
    .result (load_value)
  );

  // Non-load source select (WB_MEM never reaches the write path from here).
  always_comb begin
    case (wb_sel_e'(in_wb_sel))
      WB_PC4:  src_value = in_pc_4_value;
      WB_IMM:  src_value = in_imm_value;
      default: src_value = in_alu_value;
    endcase
  end

  always_comb begin
    state_n    = state;
    timer_n    = timer;
    rf_we_n    = 1'b0;
    rf_waddr_n = rf_waddr;
    rf_wdata_n = rf_wdata;
    mis_n      = 1'b0;
    to_n       = 1'b0;
    case (state)
      IDLE: begin
        // mem_rvalid is deliberately not looked at here.
        if (in_valid) begin
          if (wb_sel_e'(in_wb_sel) != WB_MEM) begin
            rf_we_n = in_reg_write && (in_rd != '0);
            if (rf_we_n) begin
              rf_waddr_n = in_rd;
              rf_wdata_n = src_value;
            end
          end else if (is_misaligned(in_load_size, in_byte_off)) begin
            mis_n = 1'b1;
          end else begin
            state_n = WAIT_MEM;
            timer_n = '0;
          end
        end
      end
      WAIT_MEM: begin
        // A response on the expiry cycle still wins over the timeout.
        if (mem_rvalid) begin
          rf_we_n = hold_reg_write && (hold_rd != '0);
          if (rf_we_n) begin
            rf_waddr_n = hold_rd;
            rf_wdata_n = load_value;
          end
          state_n = IDLE;
        end else if (timer == TIMER_LAST) begin
          to_n    = 1'b1;
          state_n = IDLE;
        end else begin
          timer_n = timer + TW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      timer           <= '0;
      rf_we           <= 1'b0;
      rf_waddr        <= '0;
      rf_wdata        <= '0;
      busy            <= 1'b0;
      load_misaligned <= 1'b0;
      bus_timeout     <= 1'b0;
    end else begin
      state           <= state_n;
      timer           <= timer_n;
      rf_we           <= rf_we_n;
      rf_waddr        <= rf_waddr_n;
      rf_wdata        <= rf_wdata_n;
      busy            <= (state_n == WAIT_MEM);
      load_misaligned <= mis_n;
      bus_timeout     <= to_n;
    end
  end

  // Hold contents are only meaningful in WAIT_MEM, so no reset is needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      hold_rd        <= in_rd;
      hold_reg_write <= in_reg_write;
      hold_size      <= in_load_size;
      hold_uns       <= in_load_uns;
      hold_off       <= in_byte_off;
    end
  end

endmodule

// File: tb/tb_writeback_stage.sv
module tb_writeback_stage;

  localparam int TMO = 8;

  logic        clk, rst;
  logic        in_valid, in_ready;
  logic [4:0]  in_rd;
  logic        in_reg_write;
  logic [1:0]  in_wb_sel, in_load_size, in_byte_off;
  logic        in_load_uns;
  logic [31:0] in_alu_value, in_pc_4_value, in_imm_value;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        busy, load_misaligned, bus_timeout, state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  logic [36:0] exp_q[$];
  logic [4:0]  last_waddr = '0;
  logic [31:0] last_wdata = '0;

  writeback_stage #(.XLEN(32), .REG_AW(5), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rd(in_rd), .in_reg_write(in_reg_write),
    .in_wb_sel(in_wb_sel), .in_load_size(in_load_size),
    .in_load_uns(in_load_uns), .in_byte_off(in_byte_off),
    .in_alu_value(in_alu_value), .in_pc_4_value(in_pc_4_value),
    .in_imm_value(in_imm_value),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .busy(busy), .load_misaligned(load_misaligned),
    .bus_timeout(bus_timeout), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] size,
                                           input logic uns, input logic [1:0] off);
    logic [31:0] s, mask;
    int bits;
    bits = (size == 2'd0) ? 8 : (size == 2'd1) ? 16 : 32;
    if (bits == 32) return w;
    s    = w >> (8 * off);
    mask = (32'd1 << bits) - 32'd1;
    s    = s & mask;
    if (!uns && s[bits-1]) s = s | ~mask;
    return s;
  endfunction

  function automatic bit ref_misaligned(input logic [1:0] size, input logic [1:0] off);
    if (size == 2'd0) return 1'b0;
    if (size == 2'd1) return off[0];
    return off != 2'd0;
  endfunction

  // ---------------- scoreboard ----------------
  always @(posedge clk) begin
    if (rst) begin
      last_waddr = '0;
      last_wdata = '0;
    end
  end

  always @(negedge clk) begin
    logic [36:0] e;
    if (!rst) begin
      if (rf_we === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("spurious_rf_we", {31'd0, rf_we}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("rf_waddr", {27'd0, rf_waddr}, {27'd0, e[36:32]});
          check("rf_wdata", rf_wdata, e[31:0]);
          last_waddr = e[36:32];
          last_wdata = e[31:0];
        end
      end else begin
        check("hold_waddr", {27'd0, rf_waddr}, {27'd0, last_waddr});
        check("hold_wdata", rf_wdata, last_wdata);
      end
    end
  end

  // ---------------- driver ----------------
  // Called at a negedge; returns at a negedge. lat = cycle of WAIT_MEM in which
  // the response arrives (1..TMO); lat = 0 means no response (timeout).
  task automatic run_op(input logic [1:0] sel, input logic [4:0] rd, input logic rw,
                        input logic [1:0] size, input logic uns, input logic [1:0] off,
                        input logic [31:0] val, input logic [31:0] rdata, input int lat);
    bit wr;
    in_valid      = 1'b1;
    in_rd         = rd;
    in_reg_write  = rw;
    in_wb_sel     = sel;
    in_load_size  = size;
    in_load_uns   = uns;
    in_byte_off   = off;
    in_alu_value  = $urandom;
    in_pc_4_value = $urandom;
    in_imm_value  = $urandom;
    case (sel)
      2'd0: in_alu_value  = val;
      2'd2: in_pc_4_value = val;
      2'd3: in_imm_value  = val;
      default: ;
    endcase
    mem_rvalid = 1'($urandom_range(0, 1));
    mem_rdata  = $urandom;
    wr = rw && (rd != 5'd0);
    check("in_ready_idle", {31'd0, in_ready}, 32'd1);
    if (sel != 2'd1) begin
      if (wr) exp_q.push_back({rd, val});
      @(negedge clk);
      in_valid   = 1'b0;
      mem_rvalid = 1'b0;
      check("rf_we_direct", {31'd0, rf_we}, {31'd0, wr});
      check("in_ready_after", {31'd0, in_ready}, 32'd1);
    end else if (ref_misaligned(size, off)) begin
      @(negedge clk);
      in_valid   = 1'b0;
      mem_rvalid = 1'b0;
      check("load_misaligned", {31'd0, load_misaligned}, 32'd1);
      check("rf_we_misaligned", {31'd0, rf_we}, 32'd0);
      check("busy_misaligned", {31'd0, busy}, 32'd0);
    end else begin
      @(negedge clk);
      in_valid = 1'b0;
      if (lat == 0) begin
        for (int k = 1; k <= TMO; k++) begin
          mem_rvalid = 1'b0;
          mem_rdata  = $urandom;
          check("busy_wait", {31'd0, busy}, 32'd1);
          check("in_ready_wait", {31'd0, in_ready}, 32'd0);
          check("no_early_timeout", {31'd0, bus_timeout}, 32'd0);
          @(negedge clk);
        end
        check("bus_timeout", {31'd0, bus_timeout}, 32'd1);
        check("busy_after_timeout", {31'd0, busy}, 32'd0);
        check("rf_we_timeout", {31'd0, rf_we}, 32'd0);
        mem_rvalid = 1'b1;
        mem_rdata  = rdata;
        @(negedge clk);
        mem_rvalid = 1'b0;
        check("timeout_one_pulse", {31'd0, bus_timeout}, 32'd0);
        check("stray_rvalid_no_we", {31'd0, rf_we}, 32'd0);
      end else begin
        for (int k = 1; k <= lat; k++) begin
          mem_rvalid = 1'b0;
          mem_rdata  = $urandom;
          check("busy_wait", {31'd0, busy}, 32'd1);
          check("in_ready_wait", {31'd0, in_ready}, 32'd0);
          if (k == lat) begin
            mem_rvalid = 1'b1;
            mem_rdata  = rdata;
            if (wr) exp_q.push_back({rd, ref_load(rdata, size, uns, off)});
          end
          @(negedge clk);
        end
        mem_rvalid = 1'b0;
        check("rf_we_load", {31'd0, rf_we}, {31'd0, wr});
        check("busy_done", {31'd0, busy}, 32'd0);
        check("no_timeout_on_resp", {31'd0, bus_timeout}, 32'd0);
      end
    end
  endtask

  task automatic reset_mid_wait();
    run_op_accept_only();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_rf_we", {31'd0, rf_we}, 32'd0);
    check("rst_rf_waddr", {27'd0, rf_waddr}, 32'd0);
    check("rst_rf_wdata", rf_wdata, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_misaligned", {31'd0, load_misaligned}, 32'd0);
    check("rst_timeout", {31'd0, bus_timeout}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hDEAD_BEEF;
    @(negedge clk);
    mem_rvalid = 1'b0;
    check("late_rvalid_no_we", {31'd0, rf_we}, 32'd0);
  endtask

  // Accepts an aligned LW and leaves it waiting for a response.
  task automatic run_op_accept_only();
    in_valid     = 1'b1;
    in_rd        = 5'd9;
    in_reg_write = 1'b1;
    in_wb_sel    = 2'd1;
    in_load_size = 2'd2;
    in_load_uns  = 1'b0;
    in_byte_off  = 2'd0;
    mem_rvalid   = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    check("busy_before_rst", {31'd0, busy}, 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_rd = '0; in_reg_write = 1'b0; in_wb_sel = '0;
    in_load_size = '0; in_load_uns = 1'b0; in_byte_off = '0;
    in_alu_value = '0; in_pc_4_value = '0; in_imm_value = '0;
    mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    check("reset_rf_we", {31'd0, rf_we}, 32'd0);
    check("reset_rf_waddr", {27'd0, rf_waddr}, 32'd0);
    check("reset_rf_wdata", rf_wdata, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    check("reset_flags", {30'd0, load_misaligned, bus_timeout}, 32'd0);
    rst = 1'b0;

    // Directed cases
    run_op(2'd0, 5'd5, 1'b1, 2'd2, 1'b0, 2'd0, 32'h1234_5678, 32'd0, 0);
    run_op(2'd0, 5'd6, 1'b1, 2'd2, 1'b0, 2'd0, 32'hA5A5_0001, 32'd0, 0);
    run_op(2'd3, 5'd7, 1'b0, 2'd2, 1'b0, 2'd0, 32'h0000_7000, 32'd0, 0);
    run_op(2'd1, 5'd8, 1'b1, 2'd0, 1'b0, 2'd3, 32'd0, 32'h80FF_0000, 3);
    run_op(2'd1, 5'd9, 1'b1, 2'd1, 1'b1, 2'd2, 32'd0, 32'hBEEF_1234, 1);
    run_op(2'd1, 5'd9, 1'b1, 2'd1, 1'b0, 2'd1, 32'd0, 32'hBEEF_1234, 1);
    run_op(2'd1, 5'd0, 1'b1, 2'd2, 1'b0, 2'd0, 32'd0, 32'hDEAD_BEEF, 2);
    run_op(2'd1, 5'd10, 1'b1, 2'd2, 1'b0, 2'd0, 32'd0, 32'h1111_2222, 0);
    run_op(2'd1, 5'd11, 1'b1, 2'd2, 1'b0, 2'd0, 32'd0, 32'hCAFE_F00D, TMO);
    run_op(2'd1, 5'd12, 1'b1, 2'd3, 1'b0, 2'd2, 32'd0, 32'h0, 1);
    run_op(2'd1, 5'd13, 1'b1, 2'd1, 1'b0, 2'd0, 32'd0, 32'h1234_8001, 2);
    reset_mid_wait();
    run_op(2'd2, 5'd1, 1'b1, 2'd2, 1'b0, 2'd0, 32'h0000_0104, 32'd0, 0);

    // Randomized ops
    for (int i = 0; i < 200; i++) begin
      logic [1:0] sel;
      int lat;
      sel = ($urandom_range(0, 1) == 0) ? 2'd1 : 2'($urandom_range(0, 3));
      lat = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, TMO);
      run_op(sel, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 3) != 0),
             2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             2'($urandom_range(0, 3)), $urandom, $urandom, lat);
    end

    repeat (3) @(negedge clk);
    check("exp_q_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
